// File: rtl/viterbi_dec.sv
// viterbi_dec: hard-decision register-exchange Viterbi decoder for the rate-1/2 code of viterbi_enc.
// Latency: 1 cycle from an accepted symbol to its decision (decision delay D-1 symbols); flush drains held bits one per cycle.
// Backpressure: no ready; o_busy is high while flushing, and symbols or flush requests seen then are dropped.
// Optional: define VITERBI_DEC_ERRCNT_EN to add o_err_cnt, a saturating best-path channel-error estimate.
module viterbi_dec #(
    parameter int                        p_size_polinom  = 3,
    parameter logic [p_size_polinom-1:0] p_polinom_0     = 3'b111,
    parameter logic [p_size_polinom-1:0] p_polinom_1     = 3'b101,
    parameter logic [p_size_polinom-1:0] p_defoult_state = 3'b000,
    parameter int                        p_tb_depth      = 15,
    parameter int                        p_metric_w      = 6
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_data,
    input  logic        i_valid,
    input  logic        i_flush,
    output logic        o_data,
    output logic        o_valid,
    output logic        o_busy
`ifdef VITERBI_DEC_ERRCNT_EN
    ,
    output logic [15:0] o_err_cnt
`endif
);

    localparam int K  = p_size_polinom;
    localparam int NS = 1 << (K - 1);
    localparam int D  = p_tb_depth;
    localparam int MW = p_metric_w;
    localparam int CW = $clog2(D + 1);

    typedef logic [NS-1:0][MW-1:0] pm_t;
    // Only D-1 survivor bits are registered: the oldest bit is consumed the
    // same cycle it is formed, so it lives only in the ACS result.
    typedef logic [NS-1:0][D-2:0]  surv_t;
    typedef logic [NS-1:0][D-1:0]  ext_t;
    typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

    localparam logic [MW-1:0]  SAT   = {MW{1'b1}};
    localparam logic [MW-1:0]  FAR   = {1'b1, {(MW-1){1'b0}}};
    localparam logic [K-2:0]   START = p_defoult_state[K-2:0];

    function automatic pm_t init_pm();
        pm_t pm;
        for (int s = 0; s < NS; s++) begin
            pm[s] = (s == int'(START)) ? '0 : FAR;
        end
        return pm;
    endfunction

    localparam pm_t PM_INIT = init_pm();

    // Encoder output {e1, e0} for the window {state, input bit}.
    function automatic logic [1:0] exp_sym(input int st, input logic u);
        logic [K-1:0] w;
        w = {st[K-2:0], u};
        return {^(w & p_polinom_1), ^(w & p_polinom_0)};
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   f_q, f_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    pm_t             pm_q, pm_d;
    surv_t           surv_q, surv_d;
    logic [D-2:0]    hold_q, hold_d;
    logic            o_data_q, o_data_d;
    logic            o_valid_q, o_valid_d;

    pm_t             acs_pm;
    ext_t            acs_surv;
    pm_t             norm_pm;
    logic [MW-1:0]   min_new;
    logic [D-1:0]    new_best;
    logic [D-2:0]    cur_best;

`ifdef VITERBI_DEC_ERRCNT_EN
    logic [MW-1:0]   min_old;
    logic [15:0]     err_sum;
    logic [15:0]     err_q, err_d;
`endif

    // Add-compare-select: saturating metric update per next state, MSB-0 predecessor wins ties.
    always_comb begin
        logic [MW:0] s0, s1;
        logic [MW:0] b0, b1;
        logic [1:0]  x0, x1;
        int          p0, p1;
        logic        u;
        s0 = '0; s1 = '0; b0 = '0; b1 = '0; x0 = '0; x1 = '0;
        p0 = 0; p1 = 0; u = 1'b0;
        acs_pm   = '0;
        acs_surv = '0;
        for (int ns = 0; ns < NS; ns++) begin
            u  = ns[0];
            p0 = ns >> 1;
            p1 = p0 + (1 << (K - 2));
            x0 = i_data ^ exp_sym(p0, u);
            x1 = i_data ^ exp_sym(p1, u);
            b0 = (MW+1)'(x0[0]) + (MW+1)'(x0[1]);
            b1 = (MW+1)'(x1[0]) + (MW+1)'(x1[1]);
            s0 = {1'b0, pm_q[p0]} + b0;
            s1 = {1'b0, pm_q[p1]} + b1;
            if (s0 > {1'b0, SAT}) s0 = {1'b0, SAT};
            if (s1 > {1'b0, SAT}) s1 = {1'b0, SAT};
            if (s1 < s0) begin
                acs_pm[ns]   = s1[MW-1:0];
                acs_surv[ns] = {surv_q[p1], u};
            end else begin
                acs_pm[ns]   = s0[MW-1:0];
                acs_surv[ns] = {surv_q[p0], u};
            end
        end
    end

    // Normalise new metrics and pick the best survivor (lowest index among zero-metric states).
    always_comb begin
        min_new = SAT;
        for (int ns = 0; ns < NS; ns++) begin
            if (acs_pm[ns] < min_new) min_new = acs_pm[ns];
        end
        norm_pm = '0;
        for (int ns = 0; ns < NS; ns++) begin
            norm_pm[ns] = acs_pm[ns] - min_new;
        end
        new_best = '0;
        for (int ns = NS - 1; ns >= 0; ns--) begin
            if (acs_pm[ns] == min_new) new_best = acs_surv[ns];
        end
        cur_best = '0;
        for (int ns = NS - 1; ns >= 0; ns--) begin
            if (pm_q[ns] == '0) cur_best = surv_q[ns];
        end
    end

`ifdef VITERBI_DEC_ERRCNT_EN
    // Best-metric growth per symbol, accumulated with saturation at all-ones.
    always_comb begin
        logic [16:0] acc;
        min_old = SAT;
        for (int s = 0; s < NS; s++) begin
            if (pm_q[s] < min_old) min_old = pm_q[s];
        end
        acc     = {1'b0, err_q} + 17'(min_new - min_old);
        err_sum = acc[16] ? 16'hFFFF : acc[15:0];
    end

    assign o_err_cnt = err_q;
`endif

    // Next state: accept symbols, enter flush, drain held bits oldest-first, re-initialise.
    always_comb begin
        logic          accept;
        logic          do_init;
        logic          run_next;
        logic [CW-1:0] f_next;
        logic [CW-1:0] fl_cnt;
        state_d   = state_q;
        f_d       = f_q;
        cnt_d     = cnt_q;
        pm_d      = pm_q;
        surv_d    = surv_q;
        hold_d    = hold_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
`ifdef VITERBI_DEC_ERRCNT_EN
        err_d     = err_q;
`endif
        accept   = i_valid && (state_q != ST_FLUSH);
        do_init  = 1'b0;
        f_next   = f_q;
        fl_cnt   = '0;
        run_next = 1'b0;
        case (state_q)
            ST_FILL, ST_RUN: begin
                if (accept) begin
                    pm_d = norm_pm;
                    for (int s = 0; s < NS; s++) begin
                        surv_d[s] = acs_surv[s][D-2:0];
                    end
`ifdef VITERBI_DEC_ERRCNT_EN
                    err_d = err_sum;
`endif
                    if (state_q == ST_FILL) f_next = f_q + CW'(1);
                    f_d = f_next;
                end
                run_next = (state_q == ST_RUN) || (f_next == CW'(D));
                if (accept && run_next) begin
                    state_d   = ST_RUN;
                    o_valid_d = 1'b1;
                    o_data_d  = new_best[D-1];
                end
                if (i_flush) begin
                    // The symbol arriving with the flush is already folded into the frozen survivor.
                    fl_cnt = run_next ? CW'(D - 1) : f_next;
                    hold_d = accept ? new_best[D-2:0] : cur_best;
                    cnt_d  = fl_cnt;
                    if (fl_cnt == '0) do_init = 1'b1;
                    else              state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                o_valid_d = 1'b1;
                o_data_d  = hold_q[cnt_q - CW'(1)];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) do_init = 1'b1;
            end
            default: do_init = 1'b1;
        endcase
        if (do_init) begin
            state_d = ST_FILL;
            f_d     = '0;
            pm_d    = PM_INIT;
            surv_d  = '0;
`ifdef VITERBI_DEC_ERRCNT_EN
            err_d   = '0;
`endif
        end
    end

    // State registers with asynchronous re-initialisation.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_FILL;
            f_q       <= '0;
            cnt_q     <= '0;
            pm_q      <= PM_INIT;
            surv_q    <= '0;
            hold_q    <= '0;
            o_data_q  <= 1'b0;
            o_valid_q <= 1'b0;
`ifdef VITERBI_DEC_ERRCNT_EN
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            cnt_q     <= cnt_d;
            pm_q      <= pm_d;
            surv_q    <= surv_d;
            hold_q    <= hold_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
`ifdef VITERBI_DEC_ERRCNT_EN
            err_q     <= err_d;
`endif
        end
    end

    // Outputs: busy is the flush state itself; data and valid come straight from flops.
    always_comb begin
        o_busy  = (state_q == ST_FLUSH);
        o_valid = o_valid_q;
        o_data  = o_data_q;
    end

endmodule

// File: tb/tb_viterbi_dec.sv
// tb_viterbi_dec: random frames encoded by a behavioural rate-1/2 encoder and fed to viterbi_dec.
// Decoded bits are collected from o_valid and compared to the source bits of each frame.
// Covers reset values, fill latency, flush draining, busy drop, simultaneous valid+flush, async reset.
module tb_viterbi_dec;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [1:0] i_data;
    logic       i_valid;
    logic       i_flush;
    logic       o_data;
    logic       o_valid;
    logic       o_busy;
`ifdef VITERBI_DEC_ERRCNT_EN
    logic [15:0] o_err_cnt;
`endif

    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    bit   src[$];
    bit   out_q[$];
    int   out_cyc[$];
    logic [1:0] enc_st;

    viterbi_dec dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_flush  (i_flush),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_busy   (o_busy)
`ifdef VITERBI_DEC_ERRCNT_EN
        ,
        .o_err_cnt(o_err_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Collect decoded bits and busy cycles away from the active edge.
    always @(negedge i_clk) begin
        if (o_valid) begin
            out_q.push_back(o_data);
            out_cyc.push_back(cyc);
        end
        if (o_busy) busy_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: window {s1, s0, u}, e0 from 111, e1 from 101.
    function automatic logic [1:0] enc_step(input bit u);
        logic [2:0] w;
        w      = {enc_st, u};
        enc_st = {enc_st[0], u};
        return {^(w & 3'b101), ^(w & 3'b111)};
    endfunction

    task automatic tick(input bit v, input logic [1:0] d, input bit fl);
        @(posedge i_clk);
        #1;
        i_valid = v;
        i_data  = d;
        i_flush = fl;
    endtask

    task automatic make_src(input int n_rand, input int n_tail);
        src.delete();
        for (int i = 0; i < n_rand; i++) src.push_back(1'($urandom_range(1, 0)));
        for (int i = 0; i < n_tail; i++) src.push_back(1'b0);
    endtask

    // Send the encoded frame; symbol ea is xor-ed with ma, eb with mb; optional flush on the last symbol.
    task automatic send_frame(input int gap_max, input int ea, input logic [1:0] ma,
                              input int eb, input logic [1:0] mb, input bit flush_last);
        logic [1:0] sym;
        enc_st = 2'b00;
        for (int i = 0; i < src.size(); i++) begin
            sym = enc_step(src[i]);
            if (i == ea) sym = sym ^ ma;
            if (i == eb) sym = sym ^ mb;
            repeat ($urandom_range(gap_max, 0)) tick(1'b0, 2'b00, 1'b0);
            tick(1'b1, sym, flush_last && (i == src.size() - 1));
        end
        tick(1'b0, 2'b00, 1'b0);
    endtask

    task automatic finish_flush();
        int n;
        n = 0;
        while (o_busy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        check("flush_ends", o_busy, 1'b0);
    endtask

    task automatic do_flush();
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b0);
        finish_flush();
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, out_q.size(), src.size());
        for (int i = 0; i < src.size() && i < out_q.size(); i++) begin
            check(tag, out_q[i], src[i]);
        end
    endtask

    initial begin
        int c15;
        int cf;
        int ones;
        int late;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_data  = 2'b00;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_o_data",  o_data,  1'b0);
        check("reset_o_valid", o_valid, 1'b0);
        check("reset_o_busy",  o_busy,  1'b0);
        #2 i_reset = 1'b0;

        // All-zero stream: 20 symbols give 6 decisions, the first right after symbol 15.
        out_q.delete(); out_cyc.delete();
        c15 = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 2'b00, 1'b0);
            if (i == 14) c15 = cyc;
        end
        tick(1'b0, 2'b00, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        check("zero_count", out_q.size(), 6);
        if (out_cyc.size() > 0) check("zero_first_cycle", out_cyc[0], c15 + 1);
        else                    check("zero_first_cycle", 0, c15 + 1);
        ones = 0;
        foreach (out_q[i]) ones += int'(out_q[i]);
        check("zero_data", ones, 0);
        do_flush();

        // Short frame: 5 symbols, flush emits 5 consecutive bits, symbols during busy are dropped.
        make_src(5, 0);
        out_q.delete(); out_cyc.delete();
        send_frame(0, -1, 2'b00, -1, 2'b00, 1'b0);
        busy_cnt = 0;
        tick(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 2'($urandom_range(3, 0)), 1'b0);
        tick(1'b0, 2'b00, 1'b0);
        finish_flush();
        check("short_busy_cycles", busy_cnt, 5);
        compare_out("short");
        if (out_cyc.size() == 5) check("short_consecutive", out_cyc[4] - out_cyc[0], 4);
        else                     check("short_consecutive", out_cyc.size(), 5);

        // Error-free round trips, with increasing random gaps between symbols.
        for (int f = 0; f < 3; f++) begin
            make_src(64, 2);
            out_q.delete(); out_cyc.delete();
            send_frame(f, -1, 2'b00, -1, 2'b00, 1'b0);
`ifdef VITERBI_DEC_ERRCNT_EN
            check("clean_err_cnt", o_err_cnt, 16'd0);
`endif
            do_flush();
            compare_out("round_trip");
        end

        // Single-bit error on symbol 10, double-bit error on symbol 40.
        make_src(64, 2);
        out_q.delete(); out_cyc.delete();
        send_frame(1, 10, 2'b01, 40, 2'b11, 1'b0);
`ifdef VITERBI_DEC_ERRCNT_EN
        check("err_cnt_three", o_err_cnt, 16'd3);
`endif
        do_flush();
        compare_out("corrected");
`ifdef VITERBI_DEC_ERRCNT_EN
        check("err_cnt_cleared", o_err_cnt, 16'd0);
`endif

        // Valid and flush together in RUN: the flush holds 14 bits, ending with that symbol.
        make_src(31, 0);
        out_q.delete(); out_cyc.delete();
        send_frame(0, -1, 2'b00, -1, 2'b00, 1'b1);
        cf = cyc - 1;
        finish_flush();
        compare_out("simultaneous");
        late = 0;
        foreach (out_cyc[i]) if (out_cyc[i] > cf + 1) late++;
        check("simultaneous_flush_bits", late, 14);

        // Asynchronous reset in the middle of a flush of an all-ones frame.
        src.delete();
        for (int i = 0; i < 20; i++) src.push_back(1'b1);
        send_frame(0, -1, 2'b00, -1, 2'b00, 1'b0);
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b0);
        repeat (3) @(posedge i_clk);
        #3;
        check("pre_reset_busy", o_busy, 1'b1);
        check("pre_reset_data", o_data, 1'b1);
        i_reset = 1'b1;
        #1;
        check("async_reset_busy",  o_busy,  1'b0);
        check("async_reset_valid", o_valid, 1'b0);
        check("async_reset_data",  o_data,  1'b0);
        #2 i_reset = 1'b0;
        make_src(64, 2);
        out_q.delete(); out_cyc.delete();
        send_frame(0, -1, 2'b00, -1, 2'b00, 1'b0);
        do_flush();
        compare_out("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
